// File: rtl/pep_mmacc_sxt_body_req.sv
// Sample-extract body request: forwards commands as body-RAM reads, tags them in flight,
// and turns each returned body coefficient into a rounded rotation modulo 2N.
module pep_mmacc_sxt_body_req #(
  parameter int LWE_COEF_W = 32,
  parameter int PID_W      = 6,
  parameter int N_SZ       = 11,
  parameter int OUTST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  a_rst,

  input  logic [PID_W-1:0]      cmd_pid,
  input  logic                  cmd_parity,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,

  output logic [PID_W-1:0]      boram_rd_pid,
  output logic                  boram_rd_parity,
  output logic                  boram_rd_vld,
  input  logic                  boram_rd_rdy,

  input  logic [LWE_COEF_W-1:0] boram_sxt_data,
  input  logic                  boram_sxt_data_vld,
  output logic                  boram_sxt_data_rdy,

  output logic [PID_W-1:0]      rot_pid,
  output logic                  rot_parity,
  output logic [N_SZ:0]         rot_val,
  output logic                  rot_vld,
  input  logic                  rot_rdy,

  input  logic                  flush,
  output logic                  flush_done
);

  localparam int TAG_W = PID_W + 1;
  localparam int PTR_W = (OUTST_MAX > 1) ? $clog2(OUTST_MAX) : 1;
  localparam int CNT_W = $clog2(OUTST_MAX + 1);
  localparam int SHIFT = LWE_COEF_W - N_SZ - 1;
  localparam int OUT_W = TAG_W + N_SZ + 1;
  localparam logic [LWE_COEF_W:0] RND_HALF = (LWE_COEF_W + 1)'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e             state_reg;
  logic [CNT_W-1:0]   outst_cnt_reg;
  logic [PTR_W-1:0]   tag_wr_ptr_reg;
  logic [PTR_W-1:0]   tag_rd_ptr_reg;
  logic [TAG_W-1:0]   tag_mem [OUTST_MAX];
  logic               out_wr_ptr_reg;
  logic               out_rd_ptr_reg;
  logic [1:0]         out_cnt_reg;
  logic [OUT_W-1:0]   out_mem [2];
  logic               flush_done_reg;

  logic               can_issue;
  logic               req_fire;
  logic               rsp_fire;
  logic               rot_fire;
  logic               tag_empty;
  logic               out_full;
  logic [LWE_COEF_W:0] rnd_sum;
  logic [N_SZ:0]      rot_calc;
  logic               sum_unused;

  function automatic logic [PTR_W-1:0] tag_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTST_MAX - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset gates issue combinationally so no request escapes while a_rst is high.
  assign can_issue = (state_reg == RUN) && (outst_cnt_reg < CNT_W'(OUTST_MAX)) && !a_rst;

  assign boram_rd_pid    = cmd_pid;
  assign boram_rd_parity = cmd_parity;
  assign boram_rd_vld    = cmd_vld & can_issue;
  assign cmd_rdy         = boram_rd_rdy & can_issue;

  // The tag FIFO occupancy always equals the outstanding-read count.
  assign tag_empty = (outst_cnt_reg == '0);
  assign out_full  = (out_cnt_reg == 2'd2);

  assign boram_sxt_data_rdy = !tag_empty && !out_full;

  assign req_fire = boram_rd_vld & boram_rd_rdy;
  assign rsp_fire = boram_sxt_data_vld & boram_sxt_data_rdy;
  assign rot_fire = rot_vld & rot_rdy;

  // Rounding modulus switch; the carry out of the kept field is discarded.
  assign rnd_sum    = {1'b0, boram_sxt_data} + RND_HALF;
  assign rot_calc   = rnd_sum[SHIFT +: N_SZ + 1];
  assign sum_unused = ^{rnd_sum[LWE_COEF_W], rnd_sum[SHIFT-1:0]};

  assign {rot_pid, rot_parity, rot_val} = out_mem[out_rd_ptr_reg];
  assign rot_vld    = (out_cnt_reg != 2'd0);
  assign flush_done = flush_done_reg;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_reg      <= RUN;
      outst_cnt_reg  <= '0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      out_wr_ptr_reg <= 1'b0;
      out_rd_ptr_reg <= 1'b0;
      out_cnt_reg    <= 2'd0;
      flush_done_reg <= 1'b0;
    end else begin
      if (req_fire && !rsp_fire)
        outst_cnt_reg <= outst_cnt_reg + 1'b1;
      else if (rsp_fire && !req_fire)
        outst_cnt_reg <= outst_cnt_reg - 1'b1;

      if (req_fire) tag_wr_ptr_reg <= tag_ptr_inc(tag_wr_ptr_reg);
      if (rsp_fire) tag_rd_ptr_reg <= tag_ptr_inc(tag_rd_ptr_reg);

      if (rsp_fire && !rot_fire)
        out_cnt_reg <= out_cnt_reg + 2'd1;
      else if (rot_fire && !rsp_fire)
        out_cnt_reg <= out_cnt_reg - 2'd1;

      if (rsp_fire) out_wr_ptr_reg <= ~out_wr_ptr_reg;
      if (rot_fire) out_rd_ptr_reg <= ~out_rd_ptr_reg;

      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN:   if (flush) state_reg <= DRAIN;
        DRAIN: begin
          if (tag_empty && (out_cnt_reg == 2'd0)) begin
            state_reg      <= DONE;
            flush_done_reg <= 1'b1;
          end
        end
        DONE:    state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  // Storage only; occupancy is tracked by the reset counters above.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_ptr_reg] <= {cmd_pid, cmd_parity};
    if (rsp_fire) out_mem[out_wr_ptr_reg] <= {tag_mem[tag_rd_ptr_reg], rot_calc};
  end

  // A response with no read outstanding is a protocol violation by the body RAM.
  property p_no_orphan_rsp;
    @(posedge clk) disable iff (a_rst) boram_sxt_data_vld |-> !tag_empty;
  endproperty
  a_no_orphan_rsp: assert property (p_no_orphan_rsp);

endmodule

// File: doc/pep_mmacc_sxt_body_req.md
PEP_MMACC_SXT_BODY_REQ -- requirements
Module: pep_mmacc_sxt_body_req

Interface
REQ-001 SHALL have parameter LWE_COEF_W, default 32: width of the LWE body coefficient.
REQ-002 SHALL have parameter PID_W, default 6: width of the PBS identifier.
REQ-003 SHALL have parameter N_SZ, default 11: log2 of the GLWE polynomial size N. Rotation values are modulo 2N.
REQ-004 SHALL have parameter OUTST_MAX, default 4: maximum number of body-RAM reads in flight, 1..8.
REQ-005 SHALL have port clk, input, 1: clock. One clock only.
REQ-006 SHALL have port a_rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have ports cmd_pid (input, PID_W), cmd_parity (input, 1), cmd_vld (input, 1) and cmd_rdy (output, 1): sample-extract command stream.
REQ-008 SHALL have ports boram_rd_pid (output, PID_W), boram_rd_parity (output, 1), boram_rd_vld (output, 1) and boram_rd_rdy (input, 1): body-RAM read request.
REQ-009 SHALL have ports boram_sxt_data (input, LWE_COEF_W), boram_sxt_data_vld (input, 1) and boram_sxt_data_rdy (output, 1): body-RAM read response, returned in request order.
REQ-010 SHALL have ports rot_pid (output, PID_W), rot_parity (output, 1), rot_val (output, N_SZ+1), rot_vld (output, 1) and rot_rdy (input, 1): rotation result.
REQ-011 SHALL have ports flush (input, 1) and flush_done (output, 1): drain request and its one-cycle completion pulse.

Function
REQ-012 SHALL drive the request channel directly from the command channel: boram_rd_pid=cmd_pid, boram_rd_parity=cmd_parity, boram_rd_vld=cmd_vld & can_issue, cmd_rdy=boram_rd_rdy & can_issue.
REQ-013 SHALL define can_issue = (state==RUN) & (outst_cnt < OUTST_MAX).
REQ-014 SHALL treat a request as fired when boram_rd_vld & boram_rd_rdy, and SHALL then push {pid, parity} into a tag FIFO of depth OUTST_MAX.
REQ-015 SHALL treat a response as fired when boram_sxt_data_vld & boram_sxt_data_rdy, and SHALL then pop the tag FIFO head.
REQ-016 SHALL increment outst_cnt on a request fire and decrement it on a response fire; a simultaneous fire SHALL leave it unchanged. outst_cnt SHALL never exceed OUTST_MAX or wrap below 0.
REQ-017 SHALL drive boram_sxt_data_rdy = tag FIFO not empty & output stage able to accept.
REQ-018 SHALL compute rot_val combinationally on the response beat, in LWE_COEF_W+1 bits: rot_val = ((data + 2^(LWE_COEF_W-N_SZ-2)) >> (LWE_COEF_W-N_SZ-1)) mod 2^(N_SZ+1). This is a rounding modulus switch; carry out of the top bit wraps to 0.
REQ-019 SHALL register {tag pid, tag parity, rot_val} into a 2-entry output FIFO, giving 1 cycle latency from response fire to rot_vld.
REQ-020 SHALL hold rot_* stable while rot_vld & !rot_rdy, and SHALL sustain full throughput (1 result/cycle) when rot_rdy stays high.
REQ-021 SHALL deliver results in command order.
REQ-022 SHALL implement the FSM states RUN, DRAIN and DONE:
- RUN -> DRAIN when flush=1.
- DRAIN -> DONE when outst_cnt==0 and the output FIFO is empty.
- DONE -> RUN unconditionally after 1 cycle.
REQ-023 SHALL block new commands in DRAIN and DONE (cmd_rdy=0), while still accepting responses and presenting outputs.
REQ-024 SHALL pulse flush_done=1 for exactly one cycle while in DONE.
REQ-025 SHALL, when flush is asserted in DRAIN or DONE, have no further effect; flush re-sampled in RUN SHALL start a new drain.
REQ-026 SHALL, when flush=1 with nothing outstanding and the output FIFO empty, go RUN -> DRAIN -> DONE, so flush_done occurs 2 cycles after flush.
REQ-027 SHALL treat a response arriving with an empty tag FIFO as a protocol error: simulation-only assertion; the beat is not accepted since boram_sxt_data_rdy=0.

Reset
REQ-028 SHALL, on a_rst=1 and asynchronously, clear: state=RUN, outst_cnt=0, tag FIFO empty, output FIFO empty, flush_done=0, rot_vld=0.
REQ-029 SHALL therefore hold boram_rd_vld=0 and cmd_rdy=0 during reset, and SHALL NOT reset data registers.
REQ-030 SHALL discard any in-flight tags when reset is asserted mid-operation; responses for them after release SHALL NOT be accepted.

Verification (LWE_COEF_W=32, N_SZ=11, OUTST_MAX=4)
REQ-031 SHALL cover single command pid=5, parity=1, then data 0x0008_0000 -> rot_pid=5, rot_parity=1, rot_val=1, one cycle after the response fire.
REQ-032 SHALL cover wrap: data 0xFFF8_0000 -> rot_val=0, and data 0x7FF0_0000 -> rot_val=0x7FF.
REQ-033 SHALL cover credit limit: 6 commands, boram_sxt_data_vld=0 -> exactly 4 requests fire and cmd_rdy=0 with outst_cnt=4; one response then allows exactly one further request.
REQ-034 SHALL cover back-pressure: rot_rdy=0 for 10 cycles with 3 responses offered -> 2 results held stable, boram_sxt_data_rdy=0 after the output FIFO fills; order of pids preserved once released.
REQ-035 SHALL cover flush with 2 reads outstanding -> cmd_rdy=0 immediately, flush_done pulses once, 1 cycle after the last result leaves, then RUN.
REQ-036 SHALL cover a_rst pulse with 3 reads outstanding -> all outputs at reset values in the same cycle, outst_cnt=0, and the next command issues normally.
